// File: rtl/cfg_write_arbiter_if.sv
// cfg_write_arbiter_if
//   Bundles the two write-request ports, the commit strobe and the
//   arbiter's status/register outputs into one connection.
//   master : requester side (drives the requests and the commit strobe)
//   slave  : arbiter side (drives ready, err, busy and reg_out)
//   Signals:
//     a_valid/a_addr/a_data/a_ready : port A (SPI write decoder)
//     b_valid/b_addr/b_data/b_ready : port B (init/test sequencer)
//     commit  : single-cycle pulse, shadow bank -> live bank
//     err     : pulse alongside the ready of an out-of-range write
//     busy    : high during the write cycle
//     reg_out : live registers, register i at [i*DATA_W +: DATA_W]
interface cfg_write_arbiter_if #(
  parameter int NREGS  = 5,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic                    a_valid;
  logic [ADDR_W-1:0]       a_addr;
  logic [DATA_W-1:0]       a_data;
  logic                    a_ready;
  logic                    b_valid;
  logic [ADDR_W-1:0]       b_addr;
  logic [DATA_W-1:0]       b_data;
  logic                    b_ready;
  logic                    commit;
  logic                    err;
  logic                    busy;
  logic [NREGS*DATA_W-1:0] reg_out;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, commit,
    input  a_ready, b_ready, err, busy, reg_out
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, commit,
    output a_ready, b_ready, err, busy, reg_out
  );
endinterface

// File: rtl/cfg_write_arbiter.sv
// cfg_write_arbiter
//   Round-robin arbiter for configuration register writes from two
//   requesters. A winner is captured in IDLE and written during the single
//   WRITE cycle that follows, so the sustained rate is one write per two
//   cycles. With SHADOW=1 writes land in a shadow bank and reach the live
//   bank only on commit; with SHADOW=0 they go straight to live.
//   Ports:
//     clk : clock, all logic on posedge
//     rst : synchronous active-high reset
//     bus : cfg_write_arbiter_if.slave (requests, commit, ready/err/busy,
//           reg_out)
//   All outputs come straight from registers.
module cfg_write_arbiter #(
  parameter int NREGS  = 5,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int SHADOW = 1
) (
  input logic                clk,
  input logic                rst,
  cfg_write_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;
  // Full-width limit: no truncation of the request address.
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NREGS);

  state_t            state_r;
  logic              last_grant_r;
  logic              stage_port_r;
  logic [ADDR_W-1:0] stage_addr_r;
  logic [DATA_W-1:0] stage_data_r;
  logic [DATA_W-1:0] shadow_r [NREGS];
  logic [DATA_W-1:0] live_r   [NREGS];
  logic              a_ready_r;
  logic              b_ready_r;
  logic              err_r;
  logic              busy_r;

  logic                    req_s;
  logic                    win_b_s;
  logic [ADDR_W-1:0]       win_addr_s;
  logic [DATA_W-1:0]       win_data_s;
  logic [NREGS*DATA_W-1:0] reg_out_s;

  // Winner selection: a lone request wins; on a tie the port that was not
  // granted last wins.
  always_comb begin
    req_s = bus.a_valid | bus.b_valid;
    if (bus.a_valid && bus.b_valid) begin
      win_b_s = (last_grant_r == PORT_A);
    end else if (bus.b_valid) begin
      win_b_s = 1'b1;
    end else begin
      win_b_s = 1'b0;
    end
    if (win_b_s) begin
      win_addr_s = bus.b_addr;
      win_data_s = bus.b_data;
    end else begin
      win_addr_s = bus.a_addr;
      win_data_s = bus.a_data;
    end
  end

  // Arbiter FSM, register banks and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      last_grant_r <= PORT_B;
      stage_port_r <= PORT_A;
      stage_addr_r <= '0;
      stage_data_r <= '0;
      a_ready_r    <= 1'b0;
      b_ready_r    <= 1'b0;
      err_r        <= 1'b0;
      busy_r       <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        shadow_r[i] <= '0;
        live_r[i]   <= '0;
      end
    end else begin
      // Commit copy comes first so a same-cycle write below overrides it
      // for its own address (bypass).
      if (SHADOW != 0 && bus.commit) begin
        for (int i = 0; i < NREGS; i++) begin
          live_r[i] <= shadow_r[i];
        end
      end
      case (state_r)
        ST_IDLE: begin
          if (req_s) begin
            stage_port_r <= win_b_s ? PORT_B : PORT_A;
            stage_addr_r <= win_addr_s;
            stage_data_r <= win_data_s;
            // Ready/err/busy are set now so they are visible during WRITE.
            a_ready_r    <= ~win_b_s;
            b_ready_r    <= win_b_s;
            err_r        <= (win_addr_s >= ADDR_LIMIT);
            busy_r       <= 1'b1;
            state_r      <= ST_WRITE;
          end else begin
            a_ready_r <= 1'b0;
            b_ready_r <= 1'b0;
            err_r     <= 1'b0;
            busy_r    <= 1'b0;
            state_r   <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          // Out-of-range addresses match no register, so the write drops.
          for (int i = 0; i < NREGS; i++) begin
            if (stage_addr_r == ADDR_W'(i)) begin
              if (SHADOW != 0) begin
                shadow_r[i] <= stage_data_r;
                if (bus.commit) begin
                  live_r[i] <= stage_data_r;
                end
              end else begin
                live_r[i] <= stage_data_r;
              end
            end
          end
          last_grant_r <= stage_port_r;
          a_ready_r    <= 1'b0;
          b_ready_r    <= 1'b0;
          err_r        <= 1'b0;
          busy_r       <= 1'b0;
          state_r      <= ST_IDLE;
        end
        default: begin
          a_ready_r <= 1'b0;
          b_ready_r <= 1'b0;
          err_r     <= 1'b0;
          busy_r    <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  // Flatten the live bank onto the output bus.
  always_comb begin
    reg_out_s = '0;
    for (int i = 0; i < NREGS; i++) begin
      reg_out_s[i*DATA_W +: DATA_W] = live_r[i];
    end
  end

  assign bus.a_ready = a_ready_r;
  assign bus.b_ready = b_ready_r;
  assign bus.err     = err_r;
  assign bus.busy    = busy_r;
  assign bus.reg_out = reg_out_s;

endmodule

// File: tb/tb_cfg_write_arbiter.sv
// tb_cfg_write_arbiter
//   Drives one SHADOW=0 and one SHADOW=1 arbiter with identical requests.
//   Directed scenarios use constant expectations; the random scenario uses
//   a transaction-level reference model of the arbitration and bank rules.
module tb_cfg_write_arbiter;
  localparam int NREGS  = 5;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  cfg_write_arbiter_if #(.NREGS(NREGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus0 ();
  cfg_write_arbiter_if #(.NREGS(NREGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();

  cfg_write_arbiter #(.NREGS(NREGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SHADOW(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave));
  cfg_write_arbiter #(.NREGS(NREGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SHADOW(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave));

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [6:0] ad, input logic [7:0] d);
    bus0.a_valid = v; bus0.a_addr = ad; bus0.a_data = d;
    bus1.a_valid = v; bus1.a_addr = ad; bus1.a_data = d;
  endtask

  task automatic drive_b(input logic v, input logic [6:0] ad, input logic [7:0] d);
    bus0.b_valid = v; bus0.b_addr = ad; bus0.b_data = d;
    bus1.b_valid = v; bus1.b_addr = ad; bus1.b_data = d;
  endtask

  task automatic drive_commit(input logic c);
    bus0.commit = c;
    bus1.commit = c;
  endtask

  task automatic do_reset();
    drive_a(1'b0, 7'd0, 8'd0);
    drive_b(1'b0, 7'd0, 8'd0);
    drive_commit(1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  // One request is granted per IDLE decision, the write lands one cycle
  // later; banks are plain arrays indexed by register number.
  int   m_live0 [NREGS];
  int   m_live1 [NREGS];
  int   m_shadow[NREGS];
  bit   m_pending;
  bit   m_last_b;
  bit   m_port_b;
  int   m_addr;
  int   m_data;
  bit   e_ar, e_br, e_err, e_busy;

  task automatic model_step(input bit r, input bit av, input int aa, input int ad,
                            input bit bv, input int ba, input int bd, input bit cm);
    if (r) begin
      for (int i = 0; i < NREGS; i++) begin m_live0[i] = 0; m_live1[i] = 0; m_shadow[i] = 0; end
      m_pending = 0; m_last_b = 1; e_ar = 0; e_br = 0; e_err = 0; e_busy = 0;
    end else begin
      if (cm) for (int i = 0; i < NREGS; i++) m_live1[i] = m_shadow[i];
      if (m_pending) begin
        if (m_addr < NREGS) begin
          m_live0[m_addr] = m_data;
          m_shadow[m_addr] = m_data;
          if (cm) m_live1[m_addr] = m_data;
        end
        m_last_b = m_port_b; m_pending = 0;
        e_ar = 0; e_br = 0; e_err = 0; e_busy = 0;
      end else if (av || bv) begin
        m_port_b  = (av && bv) ? !m_last_b : bv;
        m_addr    = m_port_b ? ba : aa;
        m_data    = m_port_b ? bd : ad;
        m_pending = 1;
        e_ar = !m_port_b; e_br = m_port_b; e_err = (m_addr >= NREGS); e_busy = 1;
      end else begin
        e_ar = 0; e_br = 0; e_err = 0; e_busy = 0;
      end
    end
  endtask

  function automatic logic [43:0] exp_vec(input int dut);
    logic [39:0] r;
    r = '0;
    for (int i = 0; i < NREGS; i++) r[i*8 +: 8] = 8'(dut == 0 ? m_live0[i] : m_live1[i]);
    return {e_ar, e_br, e_err, e_busy, r};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive_a(1'b1, 7'd1, 8'h77);
    drive_b(1'b1, 7'd2, 8'h66);
    drive_commit(1'b1);
    tick();
    tick();
    vectors++;
    if ({bus0.a_ready, bus0.b_ready, bus0.err, bus0.busy, bus0.reg_out} !== 44'h0) begin
      miscompares++;
      $display("FAIL reset_dut0 got %h exp %h", {bus0.a_ready, bus0.b_ready, bus0.err, bus0.busy, bus0.reg_out}, 44'h0);
    end
    vectors++;
    if ({bus1.a_ready, bus1.b_ready, bus1.err, bus1.busy, bus1.reg_out} !== 44'h0) begin
      miscompares++;
      $display("FAIL reset_dut1 got %h exp %h", {bus1.a_ready, bus1.b_ready, bus1.err, bus1.busy, bus1.reg_out}, 44'h0);
    end
    do_reset();
  endtask

  task automatic test_single_write();
    do_reset();
    drive_a(1'b1, 7'd2, 8'hA5);
    tick();
    vectors++;
    if ({bus0.a_ready, bus0.b_ready, bus0.err, bus0.busy, bus0.reg_out} !== {4'b1001, 40'h0}) begin
      miscompares++;
      $display("FAIL single_accept got %h exp %h", {bus0.a_ready, bus0.b_ready, bus0.err, bus0.busy, bus0.reg_out}, {4'b1001, 40'h0});
    end
    drive_a(1'b0, 7'd0, 8'd0);
    tick();
    vectors++;
    if ({bus0.a_ready, bus0.b_ready, bus0.err, bus0.busy, bus0.reg_out} !== {4'b0000, 40'h00_00_A5_00_00}) begin
      miscompares++;
      $display("FAIL single_write got %h exp %h", {bus0.a_ready, bus0.b_ready, bus0.err, bus0.busy, bus0.reg_out}, {4'b0000, 40'h00_00_A5_00_00});
    end
    vectors++;
    if (bus1.reg_out !== 40'h0) begin
      miscompares++;
      $display("FAIL single_shadow_hidden got %h exp %h", bus1.reg_out, 40'h0);
    end
  endtask

  task automatic test_tie_round_robin();
    do_reset();
    drive_a(1'b1, 7'd0, 8'h11);
    drive_b(1'b1, 7'd0, 8'h22);
    tick();
    vectors++;
    if ({bus0.a_ready, bus0.b_ready} !== 2'b10) begin
      miscompares++; $display("FAIL tie1_first got %b exp %b", {bus0.a_ready, bus0.b_ready}, 2'b10);
    end
    drive_a(1'b0, 7'd0, 8'd0);
    tick();
    tick();
    vectors++;
    if ({bus0.a_ready, bus0.b_ready} !== 2'b01) begin
      miscompares++; $display("FAIL tie1_second got %b exp %b", {bus0.a_ready, bus0.b_ready}, 2'b01);
    end
    drive_b(1'b0, 7'd0, 8'd0);
    tick();
    vectors++;
    if (bus0.reg_out !== 40'h22) begin
      miscompares++; $display("FAIL tie1_reg0 got %h exp %h", bus0.reg_out, 40'h22);
    end
    // A lone A grant makes A the last winner, so the next tie goes to B.
    drive_a(1'b1, 7'd1, 8'h33);
    tick();
    drive_a(1'b0, 7'd0, 8'd0);
    tick();
    drive_a(1'b1, 7'd2, 8'h44);
    drive_b(1'b1, 7'd3, 8'h55);
    tick();
    vectors++;
    if ({bus0.a_ready, bus0.b_ready} !== 2'b01) begin
      miscompares++; $display("FAIL tie2_first got %b exp %b", {bus0.a_ready, bus0.b_ready}, 2'b01);
    end
    drive_b(1'b0, 7'd0, 8'd0);
    tick();
    tick();
    vectors++;
    if ({bus0.a_ready, bus0.b_ready} !== 2'b10) begin
      miscompares++; $display("FAIL tie2_second got %b exp %b", {bus0.a_ready, bus0.b_ready}, 2'b10);
    end
    drive_a(1'b0, 7'd0, 8'd0);
    tick();
    vectors++;
    if (bus0.reg_out !== 40'h00_55_44_33_22) begin
      miscompares++; $display("FAIL tie2_regs got %h exp %h", bus0.reg_out, 40'h00_55_44_33_22);
    end
  endtask

  task automatic test_out_of_range();
    logic [6:0] addrs [4];
    logic       exp_err;
    addrs = '{7'd4, 7'd5, 7'h7F, 7'h44};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_err = (addrs[i] >= 7'd5);
      drive_a(1'b1, addrs[i], exp_err ? 8'hEE : 8'h3C);
      tick();
      vectors++;
      if ({bus0.a_ready, bus0.err, bus0.busy} !== {1'b1, exp_err, 1'b1}) begin
        miscompares++;
        $display("FAIL range_addr_%h got %b exp %b", addrs[i], {bus0.a_ready, bus0.err, bus0.busy}, {1'b1, exp_err, 1'b1});
      end
      drive_a(1'b0, 7'd0, 8'd0);
      tick();
      vectors++;
      if ({bus0.err, bus0.reg_out} !== {1'b0, 40'h3C_00_00_00_00}) begin
        miscompares++;
        $display("FAIL range_regs_%h got %h exp %h", addrs[i], {bus0.err, bus0.reg_out}, {1'b0, 40'h3C_00_00_00_00});
      end
    end
  endtask

  task automatic test_shadow_commit();
    do_reset();
    drive_a(1'b1, 7'd0, 8'h01);
    tick();
    drive_a(1'b0, 7'd0, 8'd0);
    tick();
    drive_b(1'b1, 7'd1, 8'h02);
    tick();
    drive_b(1'b0, 7'd0, 8'd0);
    tick();
    vectors++;
    if ({bus1.reg_out, bus0.reg_out} !== {40'h0, 40'h02_01}) begin
      miscompares++; $display("FAIL shadow_pre_commit got %h exp %h", {bus1.reg_out, bus0.reg_out}, {40'h0, 40'h02_01});
    end
    drive_commit(1'b1);
    tick();
    drive_commit(1'b0);
    vectors++;
    if (bus1.reg_out !== 40'h02_01) begin
      miscompares++; $display("FAIL shadow_commit got %h exp %h", bus1.reg_out, 40'h02_01);
    end
    drive_a(1'b1, 7'd4, 8'hFF);
    tick();
    drive_a(1'b0, 7'd0, 8'd0);
    drive_commit(1'b1);
    tick();
    drive_commit(1'b0);
    vectors++;
    if ({bus1.reg_out, bus0.reg_out} !== {40'hFF_00_00_02_01, 40'hFF_00_00_02_01}) begin
      miscompares++; $display("FAIL shadow_bypass got %h exp %h", {bus1.reg_out, bus0.reg_out}, {40'hFF_00_00_02_01, 40'hFF_00_00_02_01});
    end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    drive_a(1'b1, 7'd3, 8'h5A);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({bus0.a_ready, bus0.b_ready, bus0.err, bus0.busy, bus0.reg_out} !== 44'h0) begin
      miscompares++;
      $display("FAIL midrst_discard got %h exp %h", {bus0.a_ready, bus0.b_ready, bus0.err, bus0.busy, bus0.reg_out}, 44'h0);
    end
    tick();
    vectors++;
    if ({bus0.a_ready, bus0.busy} !== 2'b11) begin
      miscompares++; $display("FAIL midrst_reaccept got %b exp %b", {bus0.a_ready, bus0.busy}, 2'b11);
    end
    drive_a(1'b0, 7'd0, 8'd0);
    tick();
    vectors++;
    if (bus0.reg_out !== 40'h00_5A_00_00_00) begin
      miscompares++; $display("FAIL midrst_write got %h exp %h", bus0.reg_out, 40'h00_5A_00_00_00);
    end
  endtask

  task automatic test_back_to_back();
    int   grants, na, nb, cyc;
    logic exp_b, prev;
    do_reset();
    drive_a(1'b1, 7'($urandom_range(0, 4)), 8'($urandom));
    drive_b(1'b1, 7'($urandom_range(0, 4)), 8'($urandom));
    grants = 0; na = 0; nb = 0; cyc = 0; exp_b = 1'b0; prev = 1'b0;
    while (grants < 20 && cyc < 80) begin
      tick();
      cyc++;
      if (bus0.a_ready || bus0.b_ready) begin
        vectors++;
        if ({bus0.a_ready, bus0.b_ready, bus1.a_ready, bus1.b_ready, prev} !== {~exp_b, exp_b, ~exp_b, exp_b, 1'b0}) begin
          miscompares++;
          $display("FAIL b2b_grant%0d got %b exp %b", grants, {bus0.a_ready, bus0.b_ready, bus1.a_ready, bus1.b_ready, prev}, {~exp_b, exp_b, ~exp_b, exp_b, 1'b0});
        end
        if (bus0.a_ready) begin
          na++; drive_a(1'b1, 7'($urandom_range(0, 4)), 8'($urandom));
        end else begin
          nb++; drive_b(1'b1, 7'($urandom_range(0, 4)), 8'($urandom));
        end
        exp_b = ~exp_b; grants++; prev = 1'b1;
      end else begin
        prev = 1'b0;
      end
    end
    drive_a(1'b0, 7'd0, 8'd0);
    drive_b(1'b0, 7'd0, 8'd0);
    tick();
    tick();
    vectors++;
    if (na != 10 || nb != 10 || grants != 20) begin
      miscompares++; $display("FAIL b2b_counts got a=%0d b=%0d exp a=10 b=10", na, nb);
    end
  endtask

  task automatic test_random();
    logic       av, bv, cm, rs;
    logic [6:0] aa, ba;
    logic [7:0] ad, bd;
    av = 1'b0; bv = 1'b0; aa = '0; ba = '0; ad = '0; bd = '0;
    do_reset();
    model_step(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
    for (int c = 0; c < 600; c++) begin
      // A requester only changes its request once it has seen ready.
      if (!av || e_ar) begin
        av = ($urandom_range(0, 2) != 0);
        aa = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 5));
        ad = 8'($urandom);
      end
      if (!bv || e_br) begin
        bv = ($urandom_range(0, 2) != 0);
        ba = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 5));
        bd = 8'($urandom);
      end
      cm = ($urandom_range(0, 7) == 0);
      rs = ($urandom_range(0, 79) == 0);
      drive_a(av, aa, ad);
      drive_b(bv, ba, bd);
      drive_commit(cm);
      rst = rs;
      model_step(rs, av, int'(aa), int'(ad), bv, int'(ba), int'(bd), cm);
      tick();
      vectors++;
      if ({bus0.a_ready, bus0.b_ready, bus0.err, bus0.busy, bus0.reg_out} !== exp_vec(0)) begin
        miscompares++;
        $display("FAIL rand_dut0 cycle %0d got %h exp %h", c, {bus0.a_ready, bus0.b_ready, bus0.err, bus0.busy, bus0.reg_out}, exp_vec(0));
      end
      vectors++;
      if ({bus1.a_ready, bus1.b_ready, bus1.err, bus1.busy, bus1.reg_out} !== exp_vec(1)) begin
        miscompares++;
        $display("FAIL rand_dut1 cycle %0d got %h exp %h", c, {bus1.a_ready, bus1.b_ready, bus1.err, bus1.busy, bus1.reg_out}, exp_vec(1));
      end
    end
    rst = 1'b0;
    drive_a(1'b0, 7'd0, 8'd0);
    drive_b(1'b0, 7'd0, 8'd0);
    drive_commit(1'b0);
  endtask

  initial begin
    rst = 1'b1;
    drive_a(1'b0, 7'd0, 8'd0);
    drive_b(1'b0, 7'd0, 8'd0);
    drive_commit(1'b0);
    test_reset();
    test_single_write();
    test_tie_round_robin();
    test_out_of_range();
    test_shadow_commit();
    test_reset_mid_write();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
